// File: rtl/outerprodrc_drain.sv
// outerprodrc_drain: run sequencer and result reader for the outer-product
// accumulator array. Clears the array, enables it for CYCLES cycles, lets the
// pipeline settle, snapshots the accumulators minus the pre-run baseline, and
// streams the elements out over valid/ready in row-major order.
//
// Optional build macro: OUTERPRODRC_DRAIN_ZSKIP_EN
//   defined   -> zero-valued results are skipped in the output stream
//   undefined -> every element is emitted, zeros included
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for iStart; baseline snapshot taken on acceptance
// CLR     | one-cycle array clear pulse
// RUN     | array enabled for exactly CYCLES cycles
// FLUSH   | FLUSHLAT settle cycles with the array disabled
// CAPTURE | result = final snapshot - baseline (modular), pick first beat
// DRAIN   | one element per accepted beat, oLast on the final one
module outerprodrc_drain #(
    parameter int ROWNUM      = 2,
    parameter int COLNUM      = 2,
    parameter int OUTBITWIDTH = 8,
    parameter int CYCLES      = 16,
    parameter int FLUSHLAT    = 2,
    localparam int NUM  = ROWNUM * COLNUM,
    localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                        iClk,
    input  logic                        iRstN,
    input  logic                        iStart,
    output logic                        oBusy,
    output logic                        oArrClr,
    output logic                        oArrEn,
    input  logic [NUM*OUTBITWIDTH-1:0]  iArrData,
    output logic                        oValid,
    input  logic                        iReady,
    output logic [OUTBITWIDTH-1:0]      oData,
    output logic [IDXW-1:0]             oIdx,
    output logic                        oLast,
    output logic                        oDone
);

    localparam int W      = OUTBITWIDTH;
    localparam int CNTMAX = (CYCLES > FLUSHLAT) ? CYCLES : FLUSHLAT;
    localparam int CNTW   = $clog2(CNTMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RUN, S_FLUSH, S_CAPTURE, S_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [CNTW-1:0]      cnt_q;
    logic [NUM*W-1:0]     base_q;
    logic [NUM*W-1:0]     res_q;
    logic [NUM*W-1:0]     diff;
    logic [NUM-1:0]       cap_mask, res_mask, sel_mask;
    logic                 valid_q, last_q, done_q;
    logic [W-1:0]         data_q;
    logic [IDXW-1:0]      idx_q;
    logic                 nxt_found, nxt_last;
    logic [IDXW-1:0]      nxt_idx;
    logic [W-1:0]         nxt_data;
    int                   search_start;
    logic                 beat_xfer;

    assign beat_xfer = valid_q && iReady;

    // State register
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (iStart) state_d = S_CLR;
            S_CLR:     state_d = S_RUN;
            S_RUN:     if (cnt_q == '0) state_d = S_FLUSH;
            S_FLUSH:   if (cnt_q == '0) state_d = S_CAPTURE;
            S_CAPTURE: state_d = nxt_found ? S_DRAIN : S_IDLE;
            S_DRAIN:   if (beat_xfer && last_q) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Array control and busy decode; only one of clear/enable per state
    always_comb begin
        oBusy   = (state_q != S_IDLE);
        oArrClr = (state_q == S_CLR);
        oArrEn  = (state_q == S_RUN);
    end

    // Run/flush down-counter; terminal count at zero
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                S_CLR:   cnt_q <= CNTW'(CYCLES - 1);
                S_RUN:   cnt_q <= (cnt_q == '0) ? CNTW'(FLUSHLAT - 1) : cnt_q - 1'b1;
                S_FLUSH: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Modular per-element difference against the baseline snapshot
    always_comb begin
        diff = '0;
        for (int e = 0; e < NUM; e++)
            diff[e*W +: W] = iArrData[e*W +: W] - base_q[e*W +: W];
    end

    // Which elements are eligible for emission
    always_comb begin
        cap_mask = '1;
        res_mask = '1;
`ifdef OUTERPRODRC_DRAIN_ZSKIP_EN
        for (int e = 0; e < NUM; e++) begin
            cap_mask[e] = |diff[e*W +: W];
            res_mask[e] = |res_q[e*W +: W];
        end
`endif
    end

    // Single-cycle search for the next eligible element and whether it is the last
    always_comb begin
        sel_mask     = (state_q == S_CAPTURE) ? cap_mask : res_mask;
        search_start = (state_q == S_CAPTURE) ? 0 : int'(idx_q) + 1;
        nxt_found    = 1'b0;
        nxt_idx      = '0;
        for (int e = NUM - 1; e >= 0; e--) begin
            if (sel_mask[e] && (e >= search_start)) begin
                nxt_found = 1'b1;
                nxt_idx   = IDXW'(e);
            end
        end
        nxt_last = 1'b1;
        for (int e = 0; e < NUM; e++)
            if (sel_mask[e] && (e > int'(nxt_idx))) nxt_last = 1'b0;
        nxt_data = (state_q == S_CAPTURE) ? diff[int'(nxt_idx)*W +: W]
                                          : res_q[int'(nxt_idx)*W +: W];
    end

    // Baseline latch at start acceptance, result buffer at capture
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            base_q <= '0;
            res_q  <= '0;
        end else begin
            if (state_q == S_IDLE && iStart) base_q <= iArrData;
            if (state_q == S_CAPTURE)        res_q  <= diff;
        end
    end

    // Registered output stream and done pulse
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_CAPTURE) begin
                if (nxt_found) begin
                    valid_q <= 1'b1;
                    data_q  <= nxt_data;
                    idx_q   <= nxt_idx;
                    last_q  <= nxt_last;
                end else begin
                    done_q  <= 1'b1;
                end
            end else if (state_q == S_DRAIN && beat_xfer) begin
                if (last_q) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    idx_q   <= '0;
                    last_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    data_q  <= nxt_data;
                    idx_q   <= nxt_idx;
                    last_q  <= nxt_last;
                end
            end
        end
    end

    assign oValid = valid_q;
    assign oData  = data_q;
    assign oIdx   = idx_q;
    assign oLast  = last_q;
    assign oDone  = done_q;

endmodule

// File: tb/tb_outerprodrc_drain.sv
// Directed bench for outerprodrc_drain with a behavioural accumulator array.
// The array model accumulates per element while oArrEn is high; its
// accumulators are never cleared, so each run is checked through the
// baseline subtraction.
module tb_outerprodrc_drain;

    localparam int N = 4;
    localparam int W = 8;

    logic           iClk  = 1'b0;
    logic           iRstN = 1'b0;
    logic           iStart = 1'b0;
    logic           iReady = 1'b0;
    logic           oBusy, oArrClr, oArrEn, oValid, oLast, oDone;
    logic [N*W-1:0] iArrData;
    logic [W-1:0]   oData;
    logic [1:0]     oIdx;

    logic [W-1:0]   base [N];
    bit   [W-1:0]   delta [N];
    int             step [N];
    int             lim  [N];
    int             en_cnt;
    bit             overlap;

    int checks = 0;
    int errors = 0;

    outerprodrc_drain dut (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iStart   (iStart),
        .oBusy    (oBusy),
        .oArrClr  (oArrClr),
        .oArrEn   (oArrEn),
        .iArrData (iArrData),
        .oValid   (oValid),
        .iReady   (iReady),
        .oData    (oData),
        .oIdx     (oIdx),
        .oLast    (oLast),
        .oDone    (oDone)
    );

    always #5 iClk = ~iClk;

    always_comb begin
        iArrData = '0;
        for (int e = 0; e < N; e++) iArrData[e*W +: W] = base[e] + delta[e];
    end

    // Array model: each element adds step[e] on its first lim[e] enabled cycles of a run
    always @(posedge iClk) begin
        if (oArrClr && oArrEn) overlap <= 1'b1;
        if (oArrClr) begin
            en_cnt <= 0;
        end else if (oArrEn) begin
            en_cnt <= en_cnt + 1;
            for (int e = 0; e < N; e++)
                if (en_cnt < lim[e]) delta[e] <= delta[e] + W'(step[e]);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_acc(input int v0, input int v1, input int v2, input int v3);
        int v[4];
        v = '{v0, v1, v2, v3};
        for (int e = 0; e < N; e++) base[e] = W'(v[e]) - delta[e];
    endtask

    task automatic set_inc(input int s0, input int s1, input int s2, input int s3,
                           input int l0, input int l1, input int l2, input int l3);
        step = '{s0, s1, s2, s3};
        lim  = '{l0, l1, l2, l3};
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ":busy"},  int'(oBusy), 0);
        chk({tag, ":clr"},   int'(oArrClr), 0);
        chk({tag, ":en"},    int'(oArrEn), 0);
        chk({tag, ":valid"}, int'(oValid), 0);
        chk({tag, ":data"},  int'(oData), 0);
        chk({tag, ":idx"},   int'(oIdx), 0);
        chk({tag, ":last"},  int'(oLast), 0);
        chk({tag, ":done"},  int'(oDone), 0);
    endtask

    // One run; d0..d3 are the hand-computed result values per element.
    task automatic run_drain(input string tag,
                             input int d0, input int d1, input int d2, input int d3,
                             input logic [7:0] rdy, input bit skip_start,
                             input int extra_k1, input int extra_k2,
                             input int abort_after, input bit chain);
        int d[4];
        int expd[$];
        int expi[$];
        int beats, dk, k;
        bit done, prev_stall;
        int prev_d, prev_i;
        d = '{d0, d1, d2, d3};
        for (int e = 0; e < N; e++) begin
`ifdef OUTERPRODRC_DRAIN_ZSKIP_EN
            if (d[e] != 0) begin
                expd.push_back(d[e]);
                expi.push_back(e);
            end
`else
            expd.push_back(d[e]);
            expi.push_back(e);
`endif
        end
        if (!skip_start) begin
            @(negedge iClk);
            iStart = 1'b1;
        end
        @(negedge iClk);
        iStart = 1'b0;
        chk({tag, ":clr_pulse"}, int'(oArrClr), 1);
        chk({tag, ":clr_no_en"}, int'(oArrEn), 0);
        chk({tag, ":done_low"},  int'(oDone), 0);
        beats = 0; dk = 0; done = 1'b0; prev_stall = 1'b0; prev_d = 0; prev_i = 0;
        for (k = 0; k < 100 && !done; k++) begin
            if (k > 0) @(negedge iClk);
            iStart = 1'b0;
            if (abort_after > 0 && beats == abort_after) begin
                iRstN = 1'b0;
                #1;
                chk_idle_outputs({tag, ":rst"});
                iReady = 1'b0;
                @(negedge iClk);
                iRstN = 1'b1;
                return;
            end
            if (k == extra_k1 || k == extra_k2) iStart = 1'b1;
            if (prev_stall) begin
                chk({tag, ":hold_data"}, int'(oData), prev_d);
                chk({tag, ":hold_idx"},  int'(oIdx), prev_i);
            end
            prev_stall = 1'b0;
            if (oDone) begin
                done = 1'b1;
                chk({tag, ":done_valid"}, int'(oValid), 0);
                chk({tag, ":beats"}, beats, expd.size());
                chk({tag, ":en_cycles"}, en_cnt, 16);
                if (chain) iStart = 1'b1;
            end else begin
                chk({tag, ":busy"}, int'(oBusy), 1);
                if (oValid) begin
                    iReady = rdy[dk % 8];
                    dk++;
                    if (iReady) begin
                        if (beats < expd.size()) begin
                            chk({tag, ":idx"},  int'(oIdx), expi[beats]);
                            chk({tag, ":data"}, int'(oData), expd[beats]);
                            chk({tag, ":last"}, int'(oLast), (beats == expd.size() - 1) ? 1 : 0);
                        end else begin
                            chk({tag, ":extra_beat"}, beats, expd.size());
                        end
                        beats++;
                    end else begin
                        prev_stall = 1'b1;
                        prev_d = int'(oData);
                        prev_i = int'(oIdx);
                    end
                end
            end
        end
        if (!done) chk({tag, ":timeout"}, 0, 1);
        if (!chain) begin
            @(negedge iClk);
            iStart = 1'b0;
            chk({tag, ":done_pulse"}, int'(oDone), 0);
            chk({tag, ":idle"}, int'(oBusy), 0);
        end
    endtask

    initial begin
        set_acc(0, 0, 0, 0);
        set_inc(1, 1, 1, 1, 16, 16, 16, 16);
        #12;
        chk_idle_outputs("reset");
        @(negedge iClk);
        iRstN = 1'b1;

        // baseline 0, +1 per cycle
        set_acc(0, 0, 0, 0);
        run_drain("basic", 16, 16, 16, 16, 8'hFF, 1'b0, -1, -1, 0, 1'b0);

        // element0 wraps 250 -> 10, others mixed
        set_acc(250, 3, 0, 100);
        set_inc(1, 2, 0, 3, 16, 16, 16, 16);
        run_drain("wrap", 16, 32, 0, 48, 8'hFF, 1'b0, -1, -1, 0, 1'b0);

        // ready pattern 0,0,1,0,1,1,0,1
        set_inc(1, 1, 1, 1, 1, 2, 3, 4);
        run_drain("bp", 1, 2, 3, 4, 8'b10110100, 1'b0, -1, -1, 0, 1'b0);

        // start pulses during RUN (k=5) and DRAIN (k=21); start again in the done cycle
        set_inc(2, 2, 2, 2, 16, 16, 16, 16);
        run_drain("ign", 32, 32, 32, 32, 8'hFF, 1'b0, 5, 21, 0, 1'b1);
        set_inc(0, 0, 1, 0, 16, 16, 16, 16);
        run_drain("chain", 0, 0, 16, 0, 8'hFF, 1'b1, -1, -1, 0, 1'b0);

        // reset after two beats, then a fresh run
        set_inc(1, 1, 1, 1, 16, 16, 16, 16);
        run_drain("abort", 16, 16, 16, 16, 8'hFF, 1'b0, -1, -1, 2, 1'b0);
        chk("post_rst:overlap", int'(overlap), 0);
        set_inc(3, 1, 4, 1, 16, 16, 16, 16);
        run_drain("fresh", 48, 16, 64, 16, 8'hFF, 1'b0, -1, -1, 0, 1'b0);

        // sparse and all-zero results
        set_inc(0, 1, 0, 1, 0, 5, 0, 7);
        run_drain("sparse", 0, 5, 0, 7, 8'hFF, 1'b0, -1, -1, 0, 1'b0);
        set_inc(0, 0, 0, 0, 16, 16, 16, 16);
        run_drain("zero", 0, 0, 0, 0, 8'hFF, 1'b0, -1, -1, 0, 1'b0);

        chk("clr_en_overlap", int'(overlap), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/outerprodrc_drain.md
Name: outerprodrc_drain

Overview:
- Sequencer and result reader for the outer-product accumulator array; it is the consumer end of the array's binary result bus.
- Runs the array for a fixed bitstream length and snapshots the ROWNUM x COLNUM accumulator matrix.
- Subtracts the pre-run baseline, because the array's accumulators are cleared only by reset.
- Streams the elements out one per beat over a valid/ready interface toward writeback.

Parameters:
ROWNUM, 2, rows of the array
COLNUM, 2, columns of the array
OUTBITWIDTH, 8, width of each accumulator element
CYCLES, 16, bitstream length in cycles for which oArrEn is held high
FLUSHLAT, 2, idle cycles after the run so the array pipeline settles before capture (>=1)

Ports:
iClk  in  1  clock
iRstN  in  1  asynchronous active-low reset
iStart  in  1  start pulse; accepted only in IDLE
oBusy  out  1  high in every state except IDLE
oArrClr  out  1  drives array iClr
oArrEn  out  1  drives array iEn
iArrData  in  ROWNUM*COLNUM*OUTBITWIDTH  array oData; element e=i*COLNUM+j at bits [e*OUTBITWIDTH +: OUTBITWIDTH]
oValid  out  1  output element valid
iReady  in  1  downstream ready
oData  out  OUTBITWIDTH  element value
oIdx  out  clog2(ROWNUM*COLNUM) (min 1)  element index e
oLast  out  1  marks the final beat of a drain
oDone  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Clock and reset: one clock, iClk. Reset is asynchronous and active-low on iRstN.
- Reset values: state=IDLE; all outputs 0; counters, baseline and result buffers 0.
- IDLE:
  - iStart=1 -> CLR. Baseline register latches iArrData on this same edge.
- CLR (1 cycle):
  - oArrClr=1, oArrEn=0 -> RUN.
- RUN (exactly CYCLES cycles):
  - oArrEn=1. Down-counter loads CYCLES-1 on entry.
  - At 0 -> FLUSH.
- FLUSH (FLUSHLAT cycles):
  - oArrEn=0.
  - At end -> CAPTURE.
- CAPTURE (1 cycle):
  - Per element: result[e] = iArrData[e] - baseline[e], modulo 2^OUTBITWIDTH, same width, no saturation.
  - Wrap-around of the accumulator between the two snapshots yields the correct modular difference.
  - -> DRAIN with element pointer at the first element to emit.
- DRAIN:
  - oValid=1. oData and oIdx reflect the pointer element. Elements go in ascending e order (row-major).
  - oValid, oData, oIdx and oLast are registered and stay stable while iReady=0.
  - A beat transfers when oValid&&iReady.
  - On transfer of a non-last beat the pointer advances, and the next element is presented the following cycle (one beat per cycle at iReady=1).
  - On transfer of the last beat: oValid drops next cycle, oDone=1 for one cycle, -> IDLE.
  - oLast=1 exactly on the final emitted element.
- iStart in any state other than IDLE: ignored, no queuing.
- oArrEn and oArrClr are never high together. oArrEn is high for exactly CYCLES cycles per start.
- Reset mid-operation (any state) returns to IDLE immediately with all outputs 0. A partially drained result is discarded.
- iStart together with the oDone cycle: oDone is asserted in IDLE, so a start in that cycle is accepted.

Optional Feature:
- Macro: OUTERPRODRC_DRAIN_ZSKIP_EN
- Defined (zero-skip):
  - Elements with result[e]==0 are not emitted.
  - The pointer jumps to the next nonzero index, so the pointer search must still yield one beat per cycle.
  - oLast marks the highest-index nonzero element.
  - If all elements are zero, CAPTURE goes straight to the oDone pulse with no beats and oValid never asserts.
- Undefined: all ROWNUM*COLNUM elements are emitted, including zeros.

Test Plan:
- Basic drain, baseline 0. Array adds +1 per element per enabled cycle, CYCLES=16, iReady=1 -> oArrEn high exactly 16 cycles; 4 beats oIdx 0..3, oData=16 each; oLast on idx 3; oDone one cycle later.
- Nonzero baseline. iArrData element0 =250 at start, element0 grows by 16 during the run (final 10 after wrap) -> oData for idx0 = 16 (modular subtract).
- Backpressure. iReady toggling 0,0,1,0,1,1,0,1 -> no beat lost or duplicated; oData and oIdx held stable while stalled; exactly 4 transfers.
- iStart pulsed during RUN and during DRAIN -> ignored; a single oDone only; a start in the oDone cycle launches a new CLR.
- Async reset asserted mid-DRAIN after 2 beats -> outputs 0 immediately; after release, an iStart runs a full fresh sequence.
- ZSKIP build, results {0,5,0,7} -> 2 beats: idx1/5, then idx3/7 with oLast. All-zero results -> no oValid, oDone pulse only.
